// File: rtl/mp_mult_scheduler.sv
// mp_mult_scheduler: sequences one D1..D4 coefficient set through a single
// shared pipelined signed multiplier (D1*D2, then D3*D4). It scales the two
// products by 9/8 and 3/8 and returns both scaled products and their sum.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE. out_valid is high only in DONE and
// stays high with stable data until out_ready is seen. The only exception is
// reset, which clears everything at once.
module mp_mult_scheduler #(
    parameter  int DW       = 16,
    parameter  int MULT_LAT = 2,
    parameter  int CNT_W    = 16,
    localparam int PW       = 2 * DW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    d1,
    input  logic [DW-1:0]    d2,
    input  logic [DW-1:0]    d3,
    input  logic [DW-1:0]    d4,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PW-1:0]    mp_a,
    output logic [PW-1:0]    mp_b,
    output logic [PW-1:0]    mp_sum,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [2:0]       dbg_state
);

    localparam int XW = PW + 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MUL_A = 3'd1,
        S_MUL_B = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic                 in_ready_q, out_valid_q;
    logic [DW-1:0]        d1_q, d2_q, d3_q, d4_q;
    logic signed [PW-1:0] prod_a_q;
    logic [PW-1:0]        mp_a_q, mp_b_q, mp_sum_q;
    logic [PW-1:0]        mp_a_d, mp_b_d, mp_sum_d;
    logic [CNT_W-1:0]     frame_q;

    // Shared multiplier pipeline: product plus a valid tag and an A/B tag
    logic [PW-1:0]        pipe_q  [MULT_LAT];
    logic                 tag_v_q [MULT_LAT];
    logic                 tag_b_q [MULT_LAT];

    logic                 accept, res_load, hs;
    logic                 issue_v, issue_b;
    logic [DW-1:0]        op_x, op_y;
    logic [PW-1:0]        issue_prod;
    logic                 mult_v, mult_b;
    logic signed [PW-1:0] mult_p;
    logic signed [XW-1:0] ax, bx, a9, b3, sum_x;

    assign accept   = (state_q == S_IDLE) && in_valid && in_ready_q;
    assign hs       = (state_q == S_DONE) && out_valid_q && out_ready;
    assign mult_v   = tag_v_q[MULT_LAT-1];
    assign mult_b   = tag_b_q[MULT_LAT-1];
    assign mult_p   = pipe_q[MULT_LAT-1];
    assign res_load = (state_q == S_DRAIN) && mult_v && mult_b;

    // Operand select for the shared multiplier: MUL_A issues D1*D2, MUL_B issues D3*D4
    always_comb begin
        issue_v    = (state_q == S_MUL_A) || (state_q == S_MUL_B);
        issue_b    = (state_q == S_MUL_B);
        op_x       = issue_b ? d3_q : d1_q;
        op_y       = issue_b ? d4_q : d2_q;
        issue_prod = $signed({{DW{op_x[DW-1]}}, op_x}) * $signed({{DW{op_y[DW-1]}}, op_y});
    end

    // Scaling by shift-add at PW+4 bits, then floor division by 8 and truncation
    always_comb begin
        ax       = XW'(prod_a_q);
        bx       = XW'(mult_p);
        a9       = ax + (ax <<< 3);
        b3       = bx + (bx <<< 1);
        mp_a_d   = PW'(a9 >>> 3);
        mp_b_d   = PW'(b3 >>> 3);
        sum_x    = (a9 >>> 3) + (b3 >>> 3);
        mp_sum_d = PW'(sum_x);
    end

    // Next-state logic for the pass sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_MUL_A;
            S_MUL_A: state_d = S_MUL_B;
            S_MUL_B: state_d = S_DRAIN;
            S_DRAIN: if (res_load) state_d = S_DONE;
            S_DONE:  if (hs) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register and registered handshake flags (in_ready rises on the handshake edge)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            frame_q     <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == S_IDLE);
            out_valid_q <= (state_d == S_DONE);
            if (hs) frame_q <= frame_q + 1'b1;
        end
    end

    // Multiplier pipeline; the A product is parked when it emerges ahead of B
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MULT_LAT; i++) begin
                pipe_q[i]  <= '0;
                tag_v_q[i] <= 1'b0;
                tag_b_q[i] <= 1'b0;
            end
            prod_a_q <= '0;
        end else begin
            pipe_q[0]  <= issue_prod;
            tag_v_q[0] <= issue_v;
            tag_b_q[0] <= issue_b;
            for (int i = 1; i < MULT_LAT; i++) begin
                pipe_q[i]  <= pipe_q[i-1];
                tag_v_q[i] <= tag_v_q[i-1];
                tag_b_q[i] <= tag_b_q[i-1];
            end
            if (mult_v && !mult_b) prod_a_q <= mult_p;
        end
    end

    // Operand latch on accept and result registers loaded only on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1_q     <= '0;
            d2_q     <= '0;
            d3_q     <= '0;
            d4_q     <= '0;
            mp_a_q   <= '0;
            mp_b_q   <= '0;
            mp_sum_q <= '0;
        end else begin
            if (accept) begin
                d1_q <= d1;
                d2_q <= d2;
                d3_q <= d3;
                d4_q <= d4;
            end
            if (res_load) begin
                mp_a_q   <= mp_a_d;
                mp_b_q   <= mp_b_d;
                mp_sum_q <= mp_sum_d;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign mp_a      = mp_a_q;
    assign mp_b      = mp_b_q;
    assign mp_sum    = mp_sum_q;
    assign busy      = (state_q != S_IDLE);
    assign frame_cnt = frame_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mp_mult_scheduler.sv
// Testbench for mp_mult_scheduler: directed coefficient sets with hand-computed
// results, a scoreboard queue filled by the driver and drained by a monitor.
module tb_mp_mult_scheduler;
  localparam int DW = 16;
  localparam int ML = 2;
  localparam int CW = 3;   // small counter so the wrap is reachable
  localparam int PW = 2 * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] d1 = '0, d2 = '0, d3 = '0, d4 = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] mp_a, mp_b, mp_sum;
  logic          busy;
  logic [CW-1:0] frame_cnt;
  logic [2:0]    dbg_state;

  mp_mult_scheduler #(.DW(DW), .MULT_LAT(ML), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4),
    .out_valid(out_valid), .out_ready(out_ready),
    .mp_a(mp_a), .mp_b(mp_b), .mp_sum(mp_sum),
    .busy(busy), .frame_cnt(frame_cnt), .dbg_state(dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] d1, d2, d3, d4;
    logic [31:0] a, b, s;
  } vec_t;
  vec_t tbl[10];

  logic [3*PW-1:0] exp_q[$];
  int              acc_q[$];
  logic [CW-1:0]   exp_frames = '0;
  bit              b2b_mode = 1'b0;
  int              last_hs = -1;
  int              errors = 0;
  int              checks = 0;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver: present a set, wait for in_ready, record expected result
  task automatic send(input int i, input bit keep);
    int n = 0;
    in_valid = 1'b1;
    d1 = tbl[i].d1; d2 = tbl[i].d2; d3 = tbl[i].d3; d4 = tbl[i].d4;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back({tbl[i].a, tbl[i].b, tbl[i].s});
      acc_q.push_back(cyc + 1);
      @(negedge clk);
      if (!keep) in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  // monitor / scoreboard
  initial begin
    bit prev_v = 1'b0;
    logic [3*PW-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        prev_v = 1'b0;
      end else begin
        if (out_valid && !prev_v) begin
          if (acc_q.size() > 0) check("latency_edges", cyc - acc_q[0] + 1, ML + 3);
          else check("spurious_valid", 1, 0);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 1, 0);
          end else begin
            e = exp_q.pop_front();
            if (acc_q.size() > 0) acc_q.delete(0);
            check("mp_a", mp_a, e[3*PW-1:2*PW]);
            check("mp_b", mp_b, e[2*PW-1:PW]);
            check("mp_sum", mp_sum, e[PW-1:0]);
            check("frame_cnt_at_hs", frame_cnt, exp_frames);
            exp_frames++;
            if (b2b_mode && last_hs >= 0) check("b2b_period", cyc + 1 - last_hs, ML + 4);
            last_hs = cyc + 1;
          end
        end
        prev_v = out_valid;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_v;
    tbl[0] = '{16'h0010, 16'h0020, 16'h0008, 16'h0016, 32'h0000_0240, 32'h0000_0042, 32'h0000_0282};
    tbl[1] = '{16'hFFF0, 16'h0020, 16'h0001, 16'hFFFF, 32'hFFFF_FDC0, 32'hFFFF_FFFF, 32'hFFFF_FDBF};
    tbl[2] = '{16'h0001, 16'h0001, 16'h0001, 16'hFFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[3] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 32'h4800_0000, 32'h1800_0000, 32'h6000_0000};
    tbl[4] = '{16'h8000, 16'h8000, 16'h0000, 16'h0000, 32'h4800_0000, 32'h0000_0000, 32'h4800_0000};
    tbl[5] = '{16'h0003, 16'h0005, 16'h0007, 16'h0002, 32'h0000_0010, 32'h0000_0005, 32'h0000_0015};
    tbl[6] = '{16'hFFFF, 16'h0001, 16'h0000, 16'h0005, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFE};
    tbl[7] = '{16'h7FFF, 16'h7FFF, 16'h0002, 16'hFFFD, 32'h47FE_E001, 32'hFFFF_FFFD, 32'h47FE_DFFE};
    tbl[8] = '{16'h0100, 16'h0100, 16'hFF00, 16'h0100, 32'h0001_2000, 32'hFFFF_A000, 32'h0000_C000};
    tbl[9] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_mp_sum", mp_sum, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_first_edge", in_ready, 1);
    @(negedge clk);

    // basic case, then signed/floor cases, then extremes
    out_ready = 1'b1;
    send(0, 1'b0);
    drain();
    check("frame_cnt_after_first", frame_cnt, 1);
    send(1, 1'b0);
    send(2, 1'b0);
    send(3, 1'b0);
    send(4, 1'b0);
    drain();

    // backpressure: outputs held, nothing accepted
    out_ready = 1'b0;
    send(8, 1'b0);
    for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = k[0];
      d1 = 16'(k * 7 + 1); d2 = 16'(k + 3); d3 = 16'(k * 5); d4 = 16'hFFFF - 16'(k);
      #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_mp_a", mp_a, tbl[8].a);
      check("bp_mp_sum", mp_sum, tbl[8].s);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_on_release", in_ready, 1);
    @(negedge clk);
    drain();

    // counter wrap through 7 -> 0
    send(5, 1'b0);
    send(6, 1'b0);
    drain();
    @(negedge clk);
    check("frame_cnt_wrap", frame_cnt, 0);
    send(7, 1'b0);
    drain();

    // reset in the middle of DRAIN aborts the set
    send(9, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("in_drain", dbg_state, 3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_mp_a", mp_a, 0);
    check("mid_rst_mp_b", mp_b, 0);
    check("mid_rst_mp_sum", mp_sum, 0);
    check("mid_rst_frame_cnt", frame_cnt, 0);
    exp_q.delete();
    acc_q.delete();
    exp_frames = '0;
    @(negedge clk);
    rst_n = 1'b1;
    saw_v = 1'b0;
    repeat (10) begin
      @(negedge clk);
      #1;
      saw_v |= out_valid;
    end
    check("aborted_no_output", saw_v, 0);
    send(3, 1'b0);
    drain();

    // back-to-back after a clean reset
    @(negedge clk);
    rst_n = 1'b0;
    exp_frames = '0;
    @(negedge clk);
    rst_n = 1'b1;
    b2b_mode = 1'b1;
    last_hs = -1;
    send(1, 1'b1);
    send(5, 1'b1);
    send(7, 1'b1);
    send(8, 1'b1);
    send(0, 1'b1);
    in_valid = 1'b0;
    drain();
    b2b_mode = 1'b0;
    @(negedge clk);
    check("b2b_frame_cnt", frame_cnt, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
